// File: rtl/fec_cc_encoder_if.sv
// Serial handshake bundle for fec_cc_encoder: uncoded bits in, coded bits plus their block index out.
interface fec_cc_encoder_if #(
    parameter int IDX_W = 8
);
    logic             data_in;
    logic             valid_in;
    logic             ready_out;
    logic             data_out;
    logic [IDX_W-1:0] data_out_index;
    logic             valid_out;
    logic             ready_in;

    // master is the encoder itself; slave is the surrounding randomizer/interleaver side
    modport master (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, data_out_index, valid_out
    );

    modport slave (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, data_out_index, valid_out
    );
endinterface

// File: rtl/fec_cc_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder (G1=171o, G2=133o), serial in, serial X,Y out.
// Optional macro FEC_PINGPONG_EN adds a second block buffer so loading overlaps encoding.
module fec_cc_encoder #(
    parameter int BLOCK_BITS = 96,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             resetN,
    fec_cc_encoder_if.master bus
);
    localparam int NCBPS = 2 * BLOCK_BITS;
    localparam int IN_W  = $clog2(BLOCK_BITS);
    localparam int PTR_W = IN_W + 1;

    typedef enum logic [1:0] {LOAD, PRIME, ENCODE} state_t;
    state_t state, state_next;

    logic [IN_W-1:0]       in_cnt;
    logic [PTR_W-1:0]      out_ptr;
    logic [6:1]            sr;
    logic [6:1]            sr_cur;
    logic [BLOCK_BITS-1:0] rd_blk;
    logic [IN_W-1:0]       bit_idx;
    logic                  ready_q, valid_q, data_q;
    logic [IDX_W-1:0]      index_q;
    logic                  accept, last_in, load_out, finish, block_pending;
    logic                  cur_bit, coded, ready_next;

`ifdef FEC_PINGPONG_EN
    logic [BLOCK_BITS-1:0] blk [2];
    logic [1:0]            full, full_next;
    logic                  wr_sel, rd_sel;
    assign rd_blk = blk[rd_sel];
`else
    logic [BLOCK_BITS-1:0] blk;
    assign rd_blk = blk;
`endif

    assign bus.ready_out      = ready_q;
    assign bus.valid_out      = valid_q;
    assign bus.data_out       = data_q;
    assign bus.data_out_index = index_q;

    always_ff @(posedge clk) begin
        if (!resetN)
            state <= LOAD;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = bus.valid_in && ready_q;
        last_in    = accept && (in_cnt == IN_W'(BLOCK_BITS - 1));
        bit_idx    = out_ptr[IN_W:1];
        cur_bit    = rd_blk[bit_idx];
        sr_cur     = sr;
        // Priming seeds the register with the block tail so the trellis ends where it starts
        if (state == PRIME) begin
            for (int k = 1; k <= 6; k++)
                sr_cur[k] = rd_blk[BLOCK_BITS-k];
        end
        coded    = out_ptr[0] ? (cur_bit ^ sr_cur[2] ^ sr_cur[3] ^ sr_cur[5] ^ sr_cur[6])
                              : (cur_bit ^ sr_cur[1] ^ sr_cur[2] ^ sr_cur[3] ^ sr_cur[6]);
        load_out = (state == PRIME) ||
                   ((state == ENCODE) && (!valid_q || bus.ready_in) && (out_ptr != PTR_W'(NCBPS)));
        finish   = (state == ENCODE) && valid_q && bus.ready_in && (out_ptr == PTR_W'(NCBPS));
`ifdef FEC_PINGPONG_EN
        full_next = full;
        if (last_in)
            full_next[wr_sel] = 1'b1;
        if (finish)
            full_next[rd_sel] = 1'b0;
        block_pending = full_next[rd_sel ^ finish];
`else
        block_pending = last_in;
`endif
        case (state)
            LOAD:    if (block_pending) state_next = PRIME;
            PRIME:   state_next = ENCODE;
            ENCODE:  if (finish) state_next = block_pending ? PRIME : LOAD;
            default: state_next = LOAD;
        endcase
`ifdef FEC_PINGPONG_EN
        ready_next = !full_next[wr_sel ^ last_in];
`else
        ready_next = (state_next == LOAD);
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            in_cnt  <= '0;
            out_ptr <= '0;
            sr      <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            index_q <= '0;
        end else begin
            ready_q <= ready_next;
            if (accept)
                in_cnt <= last_in ? '0 : in_cnt + IN_W'(1);
            // out_ptr is the next coded bit to present; the register shifts after each Y bit
            if (load_out) begin
                data_q  <= coded;
                index_q <= IDX_W'(out_ptr);
                valid_q <= 1'b1;
                out_ptr <= out_ptr + PTR_W'(1);
                sr      <= out_ptr[0] ? {sr_cur[5:1], cur_bit} : sr_cur;
            end else if (finish) begin
                valid_q <= 1'b0;
                out_ptr <= '0;
            end
        end
    end

`ifdef FEC_PINGPONG_EN
    always_ff @(posedge clk) begin
        if (!resetN) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            full   <= full_next;
            wr_sel <= wr_sel ^ last_in;
            rd_sel <= rd_sel ^ finish;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            blk[wr_sel][in_cnt] <= bus.data_in;
    end
`else
    always_ff @(posedge clk) begin
        if (accept)
            blk[in_cnt] <= bus.data_in;
    end
`endif
endmodule

// File: doc/fec_cc_encoder.md
Name: fec_cc_encoder

Overview:
- Rate-1/2 tail-biting convolutional encoder (K=7, G1=171o, G2=133o) for the WiMAX QPSK path.
- Sits directly upstream of the interleaver.
- Collects a 96-bit randomized data block serially, then emits the 192 coded bits serially in X,Y order with a ready/valid handshake.
- Output stream plus index drives the interleaver's buffer write side.

Parameters:
- BLOCK_BITS, 96, uncoded bits per FEC block. Ncbps = 2*BLOCK_BITS.
- IDX_W, 8, width of data_out_index. Must satisfy 2^IDX_W >= 2*BLOCK_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  synchronous active-low reset.
- data_in  input  1  uncoded bit from the randomizer.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  encoder can accept data_in.
- data_out  output  1  coded bit.
- data_out_index  output  IDX_W  position of data_out in the coded block, 0..2*BLOCK_BITS-1.
- valid_out  output  1  data_out/data_out_index are valid.
- ready_in  input  1  downstream accepts data_out.

Behaviour:
- Reset: one clock, synchronous, active-low, sampled on the rising edge of clk while resetN=0.
- Reset values: ready_out=0, valid_out=0, data_out=0, data_out_index=0. FSM goes to LOAD, counters clear, buffer contents are don't-care.
- In the first cycle after reset release, ready_out=1.
- Input handshake: a bit is taken when valid_in && ready_out. Bit k of the block (k=0 first) is stored at buffer[k].
- LOAD state:
  - ready_out=1, valid_out=0.
  - The in-counter increments per accepted bit.
  - On acceptance of bit BLOCK_BITS-1, move to PRIME and drop ready_out the next cycle.
- PRIME state (1 cycle):
  - Load the shift register with D1=u[95], D2=u[94], D3=u[93], D4=u[92], D5=u[91], D6=u[90], i.e. Dk=u[BLOCK_BITS-k].
  - This makes the encoder tail-biting: end state equals start state.
  - Clear the out-counter n, then go to ENCODE.
- ENCODE state:
  - For input bit i=n>>1:
    - X = u[i]^D1^D2^D3^D6
    - Y = u[i]^D2^D3^D5^D6
  - data_out = X when n is even, Y when n is odd. data_out_index = n.
  - valid_out=1 throughout ENCODE.
  - Outputs are registered and hold stable while valid_out && !ready_in.
  - On an output handshake (valid_out && ready_in), n increments. After an odd n, the shift register shifts: D6..D2 <= D5..D1, D1 <= u[i].
  - On the handshake with n=2*BLOCK_BITS-1, valid_out drops the next cycle and the FSM returns to LOAD.
- Latency: first coded bit is valid 2 cycles after the last input bit is accepted.
- Throughput: 1 output bit per cycle when ready_in=1.
- Counters wrap only by FSM return. The index never exceeds 191.
- ready_in may toggle arbitrarily; no bit is lost or duplicated.
- valid_in is ignored when ready_out=0.
- Reset asserted mid-LOAD or mid-ENCODE aborts the block and clears everything per the reset values. No partial block is emitted afterwards.

Optional Feature:
- Macro: FEC_PINGPONG_EN.
- Defined:
  - Two block buffers. LOAD of block N+1 into the free buffer proceeds concurrently with ENCODE of block N, so ready_out stays 1 unless both buffers are full.
  - The buffers swap when ENCODE finishes and the other buffer is complete. PRIME follows immediately, giving a 1-cycle gap in valid_out between blocks.
  - Blocks are emitted in arrival order.
- Not defined: single buffer. ready_out=0 from PRIME through the end of ENCODE.

Test Plan:
- All-zero block (96 zeros) -> 192 zeros, indices 0..191 in order, valid_out contiguous with ready_in=1.
- All-ones block -> 192 ones (every tap sum is odd).
- Impulse at u[0]=1, rest 0:
  - out bits 0..13 = 1,1, 1,0, 1,1, 1,1, 0,0, 0,1, 1,1
  - bits 14..191 = 0
- Tail-biting impulse at u[95]=1, rest 0:
  - out bits 0..11 = 1,0, 1,1, 1,1, 0,0, 0,1, 1,1
  - bits 190,191 = 1,1
  - all others 0
- Backpressure with the impulse block, ready_in toggled 1-0-0-1 pseudo-randomly:
  - Same 192-bit sequence as the impulse test; data_out and index held while stalled.
  - valid_in gaps during LOAD do not change the result.
- resetN=0 for 1 cycle at out index 50, then a fresh all-ones block:
  - Outputs reset the next cycle; ready_out=1 after release.
  - Next output is 192 ones with index starting at 0.
  - With FEC_PINGPONG_EN: two back-to-back impulse blocks give identical consecutive outputs, ready_out stays high during the first ENCODE, and there is a 1-cycle valid_out gap.
